// File: rtl/serial_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_port_responder
//  Purpose  : Device-side end of the board serial-port handshake. Responds to
//             the host's active-low rdn/wrn strobes on an 8-bit bus, holds one
//             receive buffer byte, one transmit holding byte (THR) and one
//             transmit shift register, and exchanges 8N1 frames on rxd/txd.
//  Ports    : clk        - system clock (only clock)
//             rst        - synchronous reset, active low
//             rdn / wrn  - host read / write strobes, active low
//             data_i     - host write data, valid while wrn low
//             data_o     - receive buffer contents
//             data_oe    - bus drive enable (~rdn, 0 during reset)
//             data_ready - receive buffer holds an unread byte
//             tbre       - transmit holding register empty
//             tsre       - transmit shift register empty (line idle)
//             overrun    - sticky: a received byte was dropped
//             rxd        - asynchronous serial input
//             txd        - serial output, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module serial_port_responder #(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       overrun,
    input  logic       rxd,
    output logic       txd
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Host strobe history and write capture
    // ------------------------------------------------------------------
    logic       r_rdn_q;
    logic       r_wrn_q;
    logic [7:0] r_data_q;     // data_i from the previous cycle
    logic [7:0] r_thr;
    logic       r_tbre;
    logic       w_rd_rise;
    logic       w_wr_rise;
    logic       w_wr_accept;
    logic       w_tx_load;

    assign w_rd_rise   = rdn & ~r_rdn_q;
    assign w_wr_rise   = wrn & ~r_wrn_q;
    assign w_wr_accept = w_wr_rise & r_tbre;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdn_q  <= 1'b1;
            r_wrn_q  <= 1'b1;
            r_data_q <= 8'h00;
            r_thr    <= 8'h00;
            r_tbre   <= 1'b1;
        end else begin
            r_rdn_q  <= rdn;
            r_wrn_q  <= wrn;
            r_data_q <= data_i;
            // On the rising edge of wrn, data_i already belongs to the next
            // bus cycle, so the byte comes from the last cycle wrn was low.
            if (w_wr_accept) begin
                r_thr <= r_data_q;
            end
            // Load (tbre=0 only) and accept (tbre=1 only) never coincide.
            if (w_tx_load) begin
                r_tbre <= 1'b1;
            end else if (w_wr_accept) begin
                r_tbre <= 1'b0;
            end
        end
    end

    assign tbre    = r_tbre;
    assign data_oe = rst & ~rdn;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t             r_tx_state, tx_state_n;
    logic [c_cnt_w-1:0] r_tx_cnt,   tx_cnt_n;
    logic [2:0]         r_tx_bit,   tx_bit_n;
    logic [7:0]         r_tx_shift, tx_shift_n;
    logic               r_txd,      txd_n;
    logic               r_tsre,     tsre_n;
    logic               w_tx_last;

    assign w_tx_last = (r_tx_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_tsre     <= 1'b1;
        end else begin
            r_tx_state <= tx_state_n;
            r_tx_cnt   <= tx_cnt_n;
            r_tx_bit   <= tx_bit_n;
            r_tx_shift <= tx_shift_n;
            r_txd      <= txd_n;
            r_tsre     <= tsre_n;
        end
    end

    always_comb begin
        tx_state_n = r_tx_state;
        tx_cnt_n   = r_tx_cnt + 1'b1;
        tx_bit_n   = r_tx_bit;
        tx_shift_n = r_tx_shift;
        txd_n      = r_txd;
        tsre_n     = r_tsre;
        w_tx_load  = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                if (!r_tbre) begin
                    w_tx_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tx_last) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = '0;
                    tx_bit_n   = 3'd0;
                    txd_n      = r_tx_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tx_last) begin
                    tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        tx_state_n = ST_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_bit_n   = r_tx_bit + 3'd1;
                        tx_shift_n = {1'b0, r_tx_shift[7:1]};
                        txd_n      = r_tx_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (w_tx_last) begin
                    tx_cnt_n = '0;
                    // A pending THR byte starts immediately: no idle gap.
                    if (!r_tbre) begin
                        w_tx_load = 1'b1;
                    end else begin
                        tx_state_n = ST_IDLE;
                        tsre_n     = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_cnt_n   = '0;
            end
        endcase
        if (w_tx_load) begin
            tx_state_n = ST_START;
            tx_cnt_n   = '0;
            tx_shift_n = r_thr;
            txd_n      = 1'b0;
            tsre_n     = 1'b0;
        end
    end

    assign txd  = r_txd;
    assign tsre = r_tsre;

    // ------------------------------------------------------------------
    // Receive path: 2-flop synchronizer and receive FSM
    // ------------------------------------------------------------------
    logic               r_rx_s1;
    logic               r_rx_s2;
    state_t             r_rx_state, rx_state_n;
    logic [c_cnt_w-1:0] r_rx_cnt,   rx_cnt_n;
    logic [2:0]         r_rx_bit,   rx_bit_n;
    logic [7:0]         r_rx_shift, rx_shift_n;
    logic               w_rx_done;   // good stop bit seen this cycle

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= rx_state_n;
            r_rx_cnt   <= rx_cnt_n;
            r_rx_bit   <= rx_bit_n;
            r_rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = r_rx_state;
        rx_cnt_n   = r_rx_cnt + 1'b1;
        rx_bit_n   = r_rx_bit;
        rx_shift_n = r_rx_shift;
        w_rx_done  = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                if (!r_rx_s2) begin
                    rx_state_n = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line half a bit in; a high here was a glitch.
                if (r_rx_cnt == c_cnt_half) begin
                    rx_cnt_n = '0;
                    rx_bit_n = 3'd0;
                    rx_state_n = r_rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == c_cnt_last) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_bit_n = r_rx_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == c_cnt_last) begin
                    rx_cnt_n   = '0;
                    rx_state_n = ST_IDLE;
                    w_rx_done  = r_rx_s2;    // stop bit 0: frame silently dropped
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
                rx_cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive buffer, data_ready and overrun
    // ------------------------------------------------------------------
    logic [7:0] r_data_o;
    logic       r_data_ready;
    logic       r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_o     <= 8'h00;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_rx_done) begin
            // A read finishing in the same cycle frees the buffer, so the
            // new byte is taken and any old overrun is cleared by that read.
            if (!r_data_ready || w_rd_rise) begin
                r_data_o     <= r_rx_shift;
                r_data_ready <= 1'b1;
                if (w_rd_rise) begin
                    r_overrun <= 1'b0;
                end
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_rd_rise) begin
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign data_o     = r_data_o;
    assign data_ready = r_data_ready;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
